// File: rtl/sha_rom_pkg.sv
// Shared constants, encodings and fetch FSM states for the SHA-256 constant EEPROMs.
package sha_rom_pkg;

    localparam int unsigned H_BASE     = 0;
    localparam int unsigned K_BASE     = 8;
    localparam int unsigned H_COUNT    = 8;
    localparam int unsigned K_COUNT    = 64;
    localparam int unsigned ROM_ADDR_W = 13;
    localparam int unsigned ACC_CNT_W  = 4;

    localparam logic KIND_H = 1'b0;
    localparam logic KIND_K = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } fetch_state_t;

    // Word offset of a constant inside the EEPROM image (H block first, then K).
    function automatic int unsigned rom_offset(input logic kind, input logic [5:0] index);
        int unsigned base;
        base = (kind == KIND_K) ? K_BASE : H_BASE;
        return base + 32'(index);
    endfunction

endpackage

// File: rtl/sha_const_fetch.sv
// Reads one SHA-256 H/K constant from four byte-lane EEPROMs per request.
module sha_const_fetch #(
    parameter int unsigned ACCESS_CYCLES = 3,
    parameter int unsigned ROM_ADDR_W    = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_kind,
    input  logic [5:0]            req_index,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [ROM_ADDR_W-1:0] rom_a,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    output logic                  rom_we_n,
    input  logic [31:0]           rom_d
);
    import sha_rom_pkg::*;

    fetch_state_t         state;
    logic [ACC_CNT_W-1:0] cnt;

    // Read-only use of the EEPROMs: the write strobe is never asserted.
    assign rom_we_n = 1'b1;

    // Fetch sequencer: address setup, timed access with chip/output enable, then hold the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rom_a     <= '0;
            rom_ce_n  <= 1'b1;
            rom_oe_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_kind == KIND_H && 32'(req_index) >= H_COUNT) begin
                            // Out-of-range H index: answer immediately, leave the bus untouched.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= RESP;
                        end else begin
                            rom_a <= ROM_ADDR_W'(rom_offset(req_kind, req_index));
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    rom_ce_n <= 1'b0;
                    rom_oe_n <= 1'b0;
                    cnt      <= ACC_CNT_W'(ACCESS_CYCLES - 1);
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        rsp_data  <= rom_d;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rom_ce_n  <= 1'b1;
                        rom_oe_n  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - ACC_CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_const_fetch.sv
// Directed bench for sha_const_fetch with a four-lane EEPROM image model.
module tb_sha_const_fetch;

    localparam int unsigned AC = 3;
    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_kind;
    logic [5:0]    req_index;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [AW-1:0] rom_a;
    logic          rom_ce_n;
    logic          rom_oe_n;
    logic          rom_we_n;
    logic [31:0]   rom_d;

    logic [31:0] rom_img [0:71];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sha_const_fetch #(.ACCESS_CYCLES(AC), .ROM_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_index(req_index),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rom_a(rom_a), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n),
        .rom_d(rom_d)
    );

    // Four byte-wide EEPROMs side by side: drive data only while both enables are low.
    always_comb begin
        if (!rom_ce_n && !rom_oe_n && rom_a < AW'(72))
            rom_d = rom_img[rom_a];
        else
            rom_d = 32'hdeadbeef;
    end

    typedef struct {
        logic        kind;
        logic [5:0]  index;
        logic [12:0] exp_a;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [0:6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, follow it cycle by cycle to the response, then retire it.
    task automatic do_req(input vec_t v, input string nm);
        int n;
        int lo_cnt;
        int lo_first;
        int lo_last;
        bit a_bad;
        logic [12:0] exp_a;
        int exp_lat;
        if (v.exp_err) exp_a = rom_a; else exp_a = v.exp_a;
        exp_lat  = v.exp_err ? 1 : int'(AC) + 2;
        lo_cnt   = 0;
        lo_first = -1;
        lo_last  = -1;
        a_bad    = 1'b0;
        req_kind  = v.kind;
        req_index = v.index;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            if (!rom_ce_n || !rom_oe_n) begin
                lo_cnt++;
                if (lo_first < 0) lo_first = n;
                lo_last = n;
            end
            if (rom_a !== exp_a) a_bad = 1'b1;
            chk({nm, "_busy"}, 32'(req_ready), 32'd0);
            step();
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_data"}, rsp_data, v.exp_data);
        chk({nm, "_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({nm, "_addr"}, 32'(a_bad ? 1 : 0) + 32'(rom_a != exp_a), 32'd0);
        chk({nm, "_lowcnt"}, 32'(lo_cnt), v.exp_err ? 32'd0 : 32'(AC));
        if (!v.exp_err) begin
            chk({nm, "_lowfirst"}, 32'(lo_first), 32'd2);
            chk({nm, "_lowlast"}, 32'(lo_last), 32'(AC + 1));
        end
        chk({nm, "_resp_ce"}, 32'({rom_ce_n, rom_oe_n, rom_we_n}), 32'h7);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({nm, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hold;
        int n;
        vec_t v;

        rom_img[0] = 32'h6a09e667; rom_img[1] = 32'hbb67ae85; rom_img[2] = 32'h3c6ef372; rom_img[3] = 32'ha54ff53a;
        rom_img[4] = 32'h510e527f; rom_img[5] = 32'h9b05688c; rom_img[6] = 32'h1f83d9ab; rom_img[7] = 32'h5be0cd19;
        rom_img[8]  = 32'h428a2f98; rom_img[9]  = 32'h71374491; rom_img[10] = 32'hb5c0fbcf; rom_img[11] = 32'he9b5dba5;
        rom_img[12] = 32'h3956c25b; rom_img[13] = 32'h59f111f1; rom_img[14] = 32'h923f82a4; rom_img[15] = 32'hab1c5ed5;
        rom_img[16] = 32'hd807aa98; rom_img[17] = 32'h12835b01; rom_img[18] = 32'h243185be; rom_img[19] = 32'h550c7dc3;
        rom_img[20] = 32'h72be5d74; rom_img[21] = 32'h80deb1fe; rom_img[22] = 32'h9bdc06a7; rom_img[23] = 32'hc19bf174;
        rom_img[24] = 32'he49b69c1; rom_img[25] = 32'hefbe4786; rom_img[26] = 32'h0fc19dc6; rom_img[27] = 32'h240ca1cc;
        rom_img[28] = 32'h2de92c6f; rom_img[29] = 32'h4a7484aa; rom_img[30] = 32'h5cb0a9dc; rom_img[31] = 32'h76f988da;
        rom_img[32] = 32'h983e5152; rom_img[33] = 32'ha831c66d; rom_img[34] = 32'hb00327c8; rom_img[35] = 32'hbf597fc7;
        rom_img[36] = 32'hc6e00bf3; rom_img[37] = 32'hd5a79147; rom_img[38] = 32'h06ca6351; rom_img[39] = 32'h14292967;
        rom_img[40] = 32'h27b70a85; rom_img[41] = 32'h2e1b2138; rom_img[42] = 32'h4d2c6dfc; rom_img[43] = 32'h53380d13;
        rom_img[44] = 32'h650a7354; rom_img[45] = 32'h766a0abb; rom_img[46] = 32'h81c2c92e; rom_img[47] = 32'h92722c85;
        rom_img[48] = 32'ha2bfe8a1; rom_img[49] = 32'ha81a664b; rom_img[50] = 32'hc24b8b70; rom_img[51] = 32'hc76c51a3;
        rom_img[52] = 32'hd192e819; rom_img[53] = 32'hd6990624; rom_img[54] = 32'hf40e3585; rom_img[55] = 32'h106aa070;
        rom_img[56] = 32'h19a4c116; rom_img[57] = 32'h1e376c08; rom_img[58] = 32'h2748774c; rom_img[59] = 32'h34b0bcb5;
        rom_img[60] = 32'h391c0cb3; rom_img[61] = 32'h4ed8aa4a; rom_img[62] = 32'h5b9cca4f; rom_img[63] = 32'h682e6ff3;
        rom_img[64] = 32'h748f82ee; rom_img[65] = 32'h78a5636f; rom_img[66] = 32'h84c87814; rom_img[67] = 32'h8cc70208;
        rom_img[68] = 32'h90befffa; rom_img[69] = 32'ha4506ceb; rom_img[70] = 32'hbef9a3f7; rom_img[71] = 32'hc67178f2;

        // kind, index, expected rom_a, expected word, expected error
        vecs[0] = '{1'b0, 6'd0,  13'd0,  32'h6a09e667, 1'b0};
        vecs[1] = '{1'b1, 6'd0,  13'd8,  32'h428a2f98, 1'b0};
        vecs[2] = '{1'b1, 6'd63, 13'd71, 32'hc67178f2, 1'b0};
        vecs[3] = '{1'b0, 6'd8,  13'd0,  32'h00000000, 1'b1};
        vecs[4] = '{1'b0, 6'd3,  13'd3,  32'ha54ff53a, 1'b0};
        vecs[5] = '{1'b1, 6'd31, 13'd39, 32'h14292967, 1'b0};
        vecs[6] = '{1'b0, 6'd63, 13'd0,  32'h00000000, 1'b1};

        rst_n = 1'b0; req_valid = 1'b0; req_kind = 1'b0; req_index = '0; rsp_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_pins", 32'({rom_ce_n, rom_oe_n, rom_we_n}), 32'h7);
        chk("rst_rom_a", 32'(rom_a), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Stalled response: H7 held for 10 cycles, stray request ignored.
        req_kind = 1'b0; req_index = 6'd7; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk("stall_latency", 32'(n), 32'(AC + 2));
        hold = rsp_data;
        chk("stall_data", rsp_data, 32'h5be0cd19);
        for (int c = 0; c < 10; c++) begin
            req_valid = (c == 4);
            req_kind  = 1'b1;
            req_index = 6'd0;
            step();
            if (rsp_data !== hold || !rsp_valid || req_ready || !rom_ce_n || !rom_oe_n) begin
                chk($sformatf("stall_cycle%0d", c),
                    {rsp_data[27:0], rsp_valid, req_ready, rom_ce_n, rom_oe_n},
                    {hold[27:0], 4'b1011});
            end else begin
                n_checks++;
            end
        end
        req_valid = 1'b0;
        chk("stall_hold_data", rsp_data, 32'h5be0cd19);
        chk("stall_rom_a", 32'(rom_a), 32'd7);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("stall_idle_valid", 32'(rsp_valid), 32'd0);
        chk("stall_idle_ready", 32'(req_ready), 32'd1);
        step();
        chk("stall_no_queue", 32'({rsp_valid, rom_ce_n}), 32'h1);

        // Reset during the second ACCESS cycle aborts the fetch.
        req_kind = 1'b0; req_index = 6'd1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("abort_in_access", 32'(rom_ce_n), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_pins", 32'({rom_ce_n, rom_oe_n}), 32'h3);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        step();
        chk("abort_quiet", 32'(rsp_valid), 32'd0);
        v = '{1'b1, 6'd7, 13'd15, 32'hab1c5ed5, 1'b0};
        do_req(v, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha_const_fetch.md
Name: sha_const_fetch

Overview:
- Initiator/reader for the four byte-lane constant EEPROMs that hold the SHA-256 H and K words.
- Accepts one constant request at a time over a valid/ready handshake and drives the shared EEPROM address and active-low control pins.
- Waits a programmable access time, then assembles the four lanes into one 32-bit word (lane 0 = MSB) and returns it on a valid/ready response channel to the hash core.

Parameters:
ACCESS_CYCLES, 3, clocks CE_n/OE_n are held low before data capture; legal range 1..15
ROM_ADDR_W, 13, EEPROM address width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block idle, can accept a request
req_kind  in  1  0 = H constant, 1 = K constant
req_index  in  6  constant index (H: 0..7, K: 0..63)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  32  constant word
rsp_err  out  1  request index out of range
rom_a  out  ROM_ADDR_W  address to all four EEPROMs
rom_ce_n  out  1  chip enable, active low, shared
rom_oe_n  out  1  output enable, active low, shared
rom_we_n  out  1  write enable, tied high (read-only use)
rom_d  in  32  lane data: [31:24] chip 1, [23:16] chip 2, [15:8] chip 3, [7:0] chip 4

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rom_a=0, rom_ce_n=1, rom_oe_n=1, rom_we_n=1, state=IDLE, counter=0.
- Reset asserted in any state returns the block to these values on the next edge. Any in-flight request is dropped.
- Address map: H -> rom_a = 0 + req_index; K -> rom_a = 8 + req_index. req_index is zero-extended to ROM_ADDR_W.
- States:
  - IDLE: req_ready=1. On req_valid, latch kind and index (accept at cycle T).
    - If kind=0 and index>7, go to RESP with rsp_err=1 and rsp_data=0. No EEPROM cycle is run; rsp_valid=1 at T+1.
    - Otherwise go to SETUP.
  - SETUP (T+1): rom_a is valid; CE_n and OE_n stay high (address setup cycle).
  - ACCESS (T+2 .. T+1+ACCESS_CYCLES): CE_n=OE_n=0 and rom_a is held. A down-counter is loaded with ACCESS_CYCLES-1.
    - On the edge ending the last ACCESS cycle: rsp_data<=rom_d, rsp_err<=0, go to RESP.
  - RESP: rsp_valid=1 (first at T+2+ACCESS_CYCLES); CE_n=OE_n=1.
    - rsp_data and rsp_err are held stable until rsp_valid&&rsp_ready. Next cycle is IDLE with rsp_valid=0.
- req_ready is 0 in all states except IDLE. A req_valid outside IDLE is ignored (no queueing).
- rom_we_n is never driven low.
- No back-to-back overlap. Minimum request-to-request spacing is ACCESS_CYCLES+3 cycles for valid requests and 2 for error requests.
- rom_a keeps its last value in IDLE and RESP (no glitching to 0).
- Counter width is 4 bits. ACCESS_CYCLES=1 gives a single ACCESS cycle.

Decomposition:
- Shared package sha_rom_pkg holds:
  - H_BASE=0, K_BASE=8, H_COUNT=8, K_COUNT=64, ROM_ADDR_W=13
  - KIND_H/KIND_K encodings
  - the fetch state enum (IDLE, SETUP, ACCESS, RESP)
- Flat module; no sub-module is warranted. The access counter is inline.

Test Plan:
- Reset, then hold rst_n high 2 cycles -> req_ready=1, rsp_valid=0, rom_ce_n=rom_oe_n=rom_we_n=1, rom_a=0.
- With the four EEPROM models attached, ACCESS_CYCLES=3, request kind=0 index=0 at T -> rom_a=0; CE_n/OE_n low exactly T+2..T+4; rsp_valid at T+5; rsp_data=32'h6a09e667, rsp_err=0.
- Request kind=1 index=0 -> rom_a=8, rsp_data=32'h428a2f98. Request kind=1 index=63 -> rom_a=71, rsp_data=32'hc67178f2.
- Request kind=0 index=8 -> rom_ce_n never low, rsp_valid at T+1, rsp_err=1, rsp_data=0.
- H index 7 with rsp_ready held low 10 cycles -> rsp_data=32'h5be0cd19 stays stable, req_ready=0. A req_valid pulse during the stall is ignored; after rsp_ready, IDLE is reached in 1 cycle.
- Assert rst_n=0 during the second ACCESS cycle -> next edge gives rom_ce_n=rom_oe_n=1, rsp_valid=0, req_ready=1. A following request completes normally with correct data.
